tl_ul_link_buffer: RTL and testbench
====================================

// Module: tl_ul_link_buffer
// PURPOSE
// - Registered TileLink-UL link buffer between the core's master port and the protocol monitor tap.
// - A channel: master -> slave FIFO. D channel: slave -> master FIFO.
// - The monitor observes the slave-side (out_a / out_d) signals, so those are fully registered and glitch-free.
// - Optional in-flight source tracker flags source-ID protocol violations early.
// PARAMETERS
// - A_DEPTH   2   A-channel FIFO entries (>=1; non-power-of-2 allowed)
// - D_DEPTH   2   D-channel FIFO entries (>=1; non-power-of-2 allowed)
// - ADDR_W    32  A address width
// - DATA_W    32  data width; MASK_W = DATA_W/8
// - SIZE_W    4   size field width
// - SRC_W     4   source ID width; tracker holds 2**SRC_W bits
// PORTS
// - clock                   in   1       single clock, all state on rising edge
// - reset                   in   1       synchronous, active-high
// - in_a_valid/in_a_ready   in/out 1/1   master-side A handshake
// - in_a_opcode/in_a_param  in   3/3     A opcode, param
// - in_a_size/in_a_source   in   SIZE_W/SRC_W
// - in_a_address/mask/data  in   ADDR_W/MASK_W/DATA_W
// - out_a_valid/out_a_ready out/in 1/1   slave-side A handshake
// - out_a_*                 out  as in_a_*  buffered A payload
// - out_d_valid/out_d_ready in/out 1/1   slave-side D handshake
// - out_d_opcode/out_d_param in  3/2
// - out_d_size/out_d_source in   SIZE_W/SRC_W
// - out_d_sink/denied/corrupt in 1/1/1
// - out_d_data              in   DATA_W
// - in_d_valid/in_d_ready   out/in 1/1   master-side D handshake
// - in_d_*                  out  as out_d_*  buffered D payload
// - a_count / d_count       out  clog2(DEPTH+1)  FIFO occupancy
// - err_dup_src/err_bad_d   out  1/1     sticky tracker errors (feature only)
// - err_src                 out  SRC_W   source of first error (feature only)
// BEHAVIOUR
// - Fire = valid & ready in the same cycle. Each FIFO pushes on input fire and pops on output fire.
// - Reset (held high): count=0, pointers=0, in_a_ready=0, out_d_ready=0, out_a_valid=0, in_d_valid=0, all errors=0, err_src=0.
// - First cycle after reset release: readies=1 and valids=0.
// - Readies are registered: ready = (count < DEPTH) as of the previous edge. No combinational path from out_*_ready to in_*_ready.
// - Valids are registered: out valid = (count != 0). Minimum latency is 1 cycle (push at edge N, visible after edge N).
// - There is no flow-through and no bypass.
// - Full FIFO with a same-cycle pop: ready is 0, so no push occurs; count decrements.
// - Non-full FIFO with push and pop in the same cycle: count is unchanged and both pointers advance.
// - Pointers wrap explicitly from DEPTH-1 to 0.
// - Payload stays stable while out valid=1 and out ready=0 (TL rule); head advances only on pop.
// - Payload fields pass through unmodified; the buffer does no opcode or size checking.
// CONFIGURATION
// - Macro TL_LINK_BUF_INFLIGHT_CHK_EN enables the in-flight source tracker.
// - Defined: bitmap[2**SRC_W]. Set bit in_a_source on in_a fire. Clear bit in_d_source on in_d fire.
// - Defined: in_a fire with the bit already set -> err_dup_src=1.
// - Defined: in_d fire with the bit clear -> err_bad_d=1.
// - Defined: same-cycle A and D on the same source -> clear is applied first, then set. Net bit=1, no error.
// - Defined: err_src latches only the first error's source. All error state clears only on reset.
// - Not defined: no bitmap is built; err_dup_src, err_bad_d and err_src are tied to 0.
// TESTING
// - Reset for 3 cycles, then release -> cycle 1: in_a_ready=1, out_a_valid=0, a_count=0.
// - Push A (source 5, addr 0x8000_0010) with out_a_ready=0 -> next cycle out_a_valid=1 with the same payload, held until out_a_ready=1.
// - A_DEPTH=2: push 3 beats with out_a_ready=0 -> in_a_ready drops after 2. a_count=2. 3rd beat accepted only after 1 pop.
// - Stream 10 D beats with in_d_ready toggling 1/0 -> order is preserved, none lost or duplicated, pointers wrap cleanly.
// - Feature: A source 3 twice with no D in between -> err_dup_src=1, err_src=3. Sticky after a later clean D.
// - Feature: D source 7 with no prior A -> err_bad_d=1. Same-cycle A and D on source 2 (already in flight) -> no error, bit stays 1.

Source files
------------

// File: rtl/tl_ul_link_buffer.sv
// tl_ul_link_buffer: registered TileLink-UL link buffer between the core's
// master port (in_*) and the slave side observed by the protocol monitor (out_*).
//   A channel : in_a_* (master) -> FIFO -> out_a_* (slave)
//   D channel : out_d_* (slave) -> FIFO -> in_d_* (master)
// Every output (readies, valids, payload, counts) comes straight from a flop,
// so the monitor tap sees glitch-free signals.
// Ports: clock, reset (sync, active-high), A/D handshakes and payloads,
//   a_count/d_count occupancy, err_dup_src/err_bad_d/err_src tracker errors.
// Optional feature: define TL_LINK_BUF_INFLIGHT_CHK_EN to build the in-flight
//   source tracker; without it the error outputs are tied to 0.

// Generic registered FIFO: registered ready/valid, registered head payload.
// Ports: push_* (write side), pop_* (read side), count (occupancy).
module tl_ul_link_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push_valid,
    output logic          push_ready,
    input  logic [W-1:0]  push_data,
    output logic          pop_valid,
    input  logic          pop_ready,
    output logic [W-1:0]  pop_data,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, wr_inc, rd_inc, rd_next;
    logic [CW-1:0] count_next, after_pop;
    logic [W-1:0]  head_next;
    logic          push, pop;

    assign push = push_valid & push_ready;
    assign pop  = pop_valid & pop_ready;

    assign wr_inc  = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    assign rd_inc  = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
    assign rd_next = pop ? rd_inc : rd_ptr;

    assign after_pop  = count - CW'(pop);
    assign count_next = after_pop + CW'(push);

    // The head register is preloaded with whatever entry sits at the next read
    // pointer. Only when the FIFO drains to empty in the same cycle as a push
    // does that entry not yet exist in mem, so the incoming data is taken.
    assign head_next = (push && after_pop == '0) ? push_data : mem[rd_next];

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            push_ready <= 1'b0;
            pop_valid  <= 1'b0;
            pop_data   <= '0;
        end else begin
            if (push) wr_ptr <= wr_inc;
            rd_ptr     <= rd_next;
            count      <= count_next;
            push_ready <= (count_next < CW'(DEPTH));
            pop_valid  <= (count_next != '0);
            pop_data   <= head_next;
        end
    end
endmodule

module tl_ul_link_buffer #(
    parameter int A_DEPTH = 2,
    parameter int D_DEPTH = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SIZE_W  = 4,
    parameter int SRC_W   = 4,
    localparam int MASK_W = DATA_W / 8,
    localparam int ACW    = $clog2(A_DEPTH + 1),
    localparam int DCW    = $clog2(D_DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_a_valid,
    output logic              in_a_ready,
    input  logic [2:0]        in_a_opcode,
    input  logic [2:0]        in_a_param,
    input  logic [SIZE_W-1:0] in_a_size,
    input  logic [SRC_W-1:0]  in_a_source,
    input  logic [ADDR_W-1:0] in_a_address,
    input  logic [MASK_W-1:0] in_a_mask,
    input  logic [DATA_W-1:0] in_a_data,
    output logic              out_a_valid,
    input  logic              out_a_ready,
    output logic [2:0]        out_a_opcode,
    output logic [2:0]        out_a_param,
    output logic [SIZE_W-1:0] out_a_size,
    output logic [SRC_W-1:0]  out_a_source,
    output logic [ADDR_W-1:0] out_a_address,
    output logic [MASK_W-1:0] out_a_mask,
    output logic [DATA_W-1:0] out_a_data,
    input  logic              out_d_valid,
    output logic              out_d_ready,
    input  logic [2:0]        out_d_opcode,
    input  logic [1:0]        out_d_param,
    input  logic [SIZE_W-1:0] out_d_size,
    input  logic [SRC_W-1:0]  out_d_source,
    input  logic              out_d_sink,
    input  logic              out_d_denied,
    input  logic              out_d_corrupt,
    input  logic [DATA_W-1:0] out_d_data,
    output logic              in_d_valid,
    input  logic              in_d_ready,
    output logic [2:0]        in_d_opcode,
    output logic [1:0]        in_d_param,
    output logic [SIZE_W-1:0] in_d_size,
    output logic [SRC_W-1:0]  in_d_source,
    output logic              in_d_sink,
    output logic              in_d_denied,
    output logic              in_d_corrupt,
    output logic [DATA_W-1:0] in_d_data,
    output logic [ACW-1:0]    a_count,
    output logic [DCW-1:0]    d_count,
    output logic              err_dup_src,
    output logic              err_bad_d,
    output logic [SRC_W-1:0]  err_src
);
    localparam int AP_W = 6 + SIZE_W + SRC_W + ADDR_W + MASK_W + DATA_W;
    localparam int DP_W = 5 + SIZE_W + SRC_W + 3 + DATA_W;

    logic [AP_W-1:0] a_in, a_out;
    logic [DP_W-1:0] d_in, d_out;

    assign a_in = {in_a_opcode, in_a_param, in_a_size, in_a_source,
                   in_a_address, in_a_mask, in_a_data};
    assign {out_a_opcode, out_a_param, out_a_size, out_a_source,
            out_a_address, out_a_mask, out_a_data} = a_out;

    assign d_in = {out_d_opcode, out_d_param, out_d_size, out_d_source,
                   out_d_sink, out_d_denied, out_d_corrupt, out_d_data};
    assign {in_d_opcode, in_d_param, in_d_size, in_d_source,
            in_d_sink, in_d_denied, in_d_corrupt, in_d_data} = d_out;

    tl_ul_link_fifo #(.DEPTH(A_DEPTH), .W(AP_W)) u_a_fifo (
        .clock(clock), .reset(reset),
        .push_valid(in_a_valid), .push_ready(in_a_ready), .push_data(a_in),
        .pop_valid(out_a_valid), .pop_ready(out_a_ready), .pop_data(a_out),
        .count(a_count)
    );

    tl_ul_link_fifo #(.DEPTH(D_DEPTH), .W(DP_W)) u_d_fifo (
        .clock(clock), .reset(reset),
        .push_valid(out_d_valid), .push_ready(out_d_ready), .push_data(d_in),
        .pop_valid(in_d_valid), .pop_ready(in_d_ready), .pop_data(d_out),
        .count(d_count)
    );

`ifdef TL_LINK_BUF_INFLIGHT_CHK_EN
    logic [2**SRC_W-1:0] inflight;
    logic a_fire, d_fire, dup_hit, bad_hit;

    assign a_fire  = in_a_valid & in_a_ready;
    assign d_fire  = in_d_valid & in_d_ready;
    assign bad_hit = d_fire & ~inflight[in_d_source];
    // A response retiring the same source this cycle frees it before the new
    // request claims it, so that case is not a duplicate.
    assign dup_hit = a_fire & inflight[in_a_source]
                   & ~(d_fire && (in_d_source == in_a_source));

    always_ff @(posedge clock) begin
        if (reset) begin
            inflight    <= '0;
            err_dup_src <= 1'b0;
            err_bad_d   <= 1'b0;
            err_src     <= '0;
        end else begin
            // Set is written after clear so it wins on a same-source collision.
            if (d_fire) inflight[in_d_source] <= 1'b0;
            if (a_fire) inflight[in_a_source] <= 1'b1;
            if ((dup_hit || bad_hit) && !err_dup_src && !err_bad_d)
                err_src <= dup_hit ? in_a_source : in_d_source;
            if (dup_hit) err_dup_src <= 1'b1;
            if (bad_hit) err_bad_d   <= 1'b1;
        end
    end
`else
    assign err_dup_src = 1'b0;
    assign err_bad_d   = 1'b0;
    assign err_src     = '0;
`endif
endmodule

// File: tb/tb_tl_ul_link_buffer.sv
module tb_tl_ul_link_buffer;
    localparam int A_DEPTH = 2, D_DEPTH = 2;
    localparam int ADDR_W = 32, DATA_W = 32, SIZE_W = 4, SRC_W = 4, MASK_W = 4;
    localparam int AW = 6 + SIZE_W + SRC_W + ADDR_W + MASK_W + DATA_W;
    localparam int DW = 5 + SIZE_W + SRC_W + 3 + DATA_W;
    localparam int DSRC_LSB = DATA_W + 3;
`ifdef TL_LINK_BUF_INFLIGHT_CHK_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic clock = 1'b0, reset = 1'b1;
    logic in_a_valid, in_a_ready, out_a_valid, out_a_ready;
    logic [2:0] in_a_opcode, in_a_param, out_a_opcode, out_a_param;
    logic [SIZE_W-1:0] in_a_size, out_a_size, out_d_size, in_d_size;
    logic [SRC_W-1:0] in_a_source, out_a_source, out_d_source, in_d_source, err_src;
    logic [ADDR_W-1:0] in_a_address, out_a_address;
    logic [MASK_W-1:0] in_a_mask, out_a_mask;
    logic [DATA_W-1:0] in_a_data, out_a_data, out_d_data, in_d_data;
    logic out_d_valid, out_d_ready, in_d_valid, in_d_ready;
    logic [2:0] out_d_opcode, in_d_opcode;
    logic [1:0] out_d_param, in_d_param;
    logic out_d_sink, out_d_denied, out_d_corrupt, in_d_sink, in_d_denied, in_d_corrupt;
    logic [1:0] a_count, d_count;
    logic err_dup_src, err_bad_d;

    always #5 clock = ~clock;

    tl_ul_link_buffer #(.A_DEPTH(A_DEPTH), .D_DEPTH(D_DEPTH), .ADDR_W(ADDR_W),
        .DATA_W(DATA_W), .SIZE_W(SIZE_W), .SRC_W(SRC_W)) dut (
        .clock(clock), .reset(reset),
        .in_a_valid(in_a_valid), .in_a_ready(in_a_ready), .in_a_opcode(in_a_opcode),
        .in_a_param(in_a_param), .in_a_size(in_a_size), .in_a_source(in_a_source),
        .in_a_address(in_a_address), .in_a_mask(in_a_mask), .in_a_data(in_a_data),
        .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
        .out_a_param(out_a_param), .out_a_size(out_a_size), .out_a_source(out_a_source),
        .out_a_address(out_a_address), .out_a_mask(out_a_mask), .out_a_data(out_a_data),
        .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode),
        .out_d_param(out_d_param), .out_d_size(out_d_size), .out_d_source(out_d_source),
        .out_d_sink(out_d_sink), .out_d_denied(out_d_denied), .out_d_corrupt(out_d_corrupt),
        .out_d_data(out_d_data),
        .in_d_valid(in_d_valid), .in_d_ready(in_d_ready), .in_d_opcode(in_d_opcode),
        .in_d_param(in_d_param), .in_d_size(in_d_size), .in_d_source(in_d_source),
        .in_d_sink(in_d_sink), .in_d_denied(in_d_denied), .in_d_corrupt(in_d_corrupt),
        .in_d_data(in_d_data),
        .a_count(a_count), .d_count(d_count),
        .err_dup_src(err_dup_src), .err_bad_d(err_bad_d), .err_src(err_src)
    );

    wire [AW-1:0] a_drv = {in_a_opcode, in_a_param, in_a_size, in_a_source,
                           in_a_address, in_a_mask, in_a_data};
    wire [AW-1:0] a_obs = {out_a_opcode, out_a_param, out_a_size, out_a_source,
                           out_a_address, out_a_mask, out_a_data};
    wire [DW-1:0] d_drv = {out_d_opcode, out_d_param, out_d_size, out_d_source,
                           out_d_sink, out_d_denied, out_d_corrupt, out_d_data};
    wire [DW-1:0] d_obs = {in_d_opcode, in_d_param, in_d_size, in_d_source,
                           in_d_sink, in_d_denied, in_d_corrupt, in_d_data};

    // Reference model: two queues plus a set of outstanding source IDs.
    logic [AW-1:0] qa[$];
    logic [DW-1:0] qd[$];
    bit rst_q;
    bit [2**SRC_W-1:0] busy;
    bit m_dup, m_bad;
    logic [SRC_W-1:0] m_src;

    int checks = 0, failures = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit a_rdy, d_rdy, a_fire, d_fire, a_pop, d_push, dup, bad;
        logic [SRC_W-1:0] ds;
        @(posedge clock);
        if (reset) begin
            qa.delete(); qd.delete();
            rst_q = 1; busy = '0; m_dup = 0; m_bad = 0; m_src = '0;
        end else begin
            a_rdy  = !rst_q && qa.size() < A_DEPTH;
            d_rdy  = !rst_q && qd.size() < D_DEPTH;
            a_fire = in_a_valid && a_rdy;
            d_push = out_d_valid && d_rdy;
            a_pop  = qa.size() != 0 && out_a_ready;
            d_fire = qd.size() != 0 && in_d_ready;
            ds     = d_fire ? qd[0][DSRC_LSB +: SRC_W] : '0;
            dup = a_fire && busy[in_a_source] && !(d_fire && ds == in_a_source);
            bad = d_fire && !busy[ds];
            if (FEAT && (dup || bad) && !m_dup && !m_bad) m_src = dup ? in_a_source : ds;
            if (FEAT && dup) m_dup = 1;
            if (FEAT && bad) m_bad = 1;
            if (d_fire) busy[ds] = 0;
            if (a_fire) busy[in_a_source] = 1;
            if (a_pop)  void'(qa.pop_front());
            if (a_fire) qa.push_back(a_drv);
            if (d_fire) void'(qd.pop_front());
            if (d_push) qd.push_back(d_drv);
            rst_q = 0;
        end
        #1;
        check("a_ready", in_a_ready, !rst_q && qa.size() < A_DEPTH);
        check("a_valid", out_a_valid, qa.size() != 0);
        check("a_count", a_count, qa.size());
        if (qa.size() != 0) check("a_payload", a_obs, qa[0]);
        check("d_ready", out_d_ready, !rst_q && qd.size() < D_DEPTH);
        check("d_valid", in_d_valid, qd.size() != 0);
        check("d_count", d_count, qd.size());
        if (qd.size() != 0) check("d_payload", d_obs, qd[0]);
        check("err_dup", err_dup_src, m_dup);
        check("err_bad", err_bad_d, m_bad);
        check("err_src", err_src, m_src);
    endtask

    task automatic rand_fields();
        in_a_opcode = 3'($urandom); in_a_param = 3'($urandom); in_a_size = 4'($urandom);
        in_a_mask = 4'($urandom); in_a_data = $urandom();
        out_d_opcode = 3'($urandom); out_d_param = 2'($urandom); out_d_size = 4'($urandom);
        out_d_sink = 1'($urandom); out_d_denied = 1'($urandom); out_d_corrupt = 1'($urandom);
        out_d_data = $urandom();
    endtask

    task automatic idle();
        in_a_valid = 0; out_d_valid = 0; out_a_ready = 1; in_d_ready = 1;
    endtask

    task automatic do_reset();
        reset = 1; idle();
        repeat (3) tick();
        reset = 0;
        tick();
    endtask

    task automatic a_beat(input logic [SRC_W-1:0] src, input logic [ADDR_W-1:0] addr);
        rand_fields();
        in_a_valid = 1; in_a_source = src; in_a_address = addr;
        tick();
        in_a_valid = 0;
    endtask

    task automatic d_beat(input logic [SRC_W-1:0] src);
        rand_fields();
        out_d_valid = 1; out_d_source = src;
        tick();
        out_d_valid = 0;
    endtask

    initial begin
        int sent, recv;
        bit fire_in, fire_out;
        rand_fields(); in_a_source = '0; in_a_address = '0; out_d_source = '0;
        do_reset();
        check("rel_a_ready", in_a_ready, 1);
        check("rel_a_valid", out_a_valid, 0);
        check("rel_a_count", a_count, 0);

        // Single A beat held while the slave stalls.
        out_a_ready = 0;
        a_beat(5, 32'h8000_0010);
        check("hold_src", out_a_source, 5);
        tick();
        check("hold_addr", out_a_address, 32'h8000_0010);
        out_a_ready = 1; tick();
        check("hold_drained", out_a_valid, 0);

        // Fill to depth, third beat waits for a pop.
        out_a_ready = 0; in_a_valid = 1;
        in_a_source = 8;  in_a_address = 32'h100; tick();
        in_a_source = 9;  in_a_address = 32'h200; tick();
        in_a_source = 10; in_a_address = 32'h300; tick();
        check("full_count", a_count, 2);
        check("full_ready", in_a_ready, 0);
        out_a_ready = 1; tick();
        check("pop_count", a_count, 1);
        out_a_ready = 0; tick();
        check("third_count", a_count, 2);
        check("third_head", out_a_address, 32'h200);
        idle(); repeat (3) tick();

        // Same-cycle A and D on an in-flight source, then a stray D.
        do_reset();
        a_beat(2, 32'h40);
        in_d_ready = 0; d_beat(2);
        in_a_valid = 1; in_a_source = 2; in_d_ready = 1; tick();
        in_a_valid = 0;
        check("same_dup", err_dup_src, 0);
        check("same_bad", err_bad_d, 0);
        d_beat(2); tick();
        check("bit_kept", err_bad_d, 0);
        d_beat(7); tick();
        check("stray_bad", err_bad_d, FEAT);
        check("stray_src", err_src, FEAT ? 7 : 0);

        // Duplicate source, sticky across a later clean response.
        do_reset();
        a_beat(3, 32'h50);
        a_beat(3, 32'h54);
        check("dup_flag", err_dup_src, FEAT);
        check("dup_src", err_src, FEAT ? 3 : 0);
        d_beat(3); tick();
        check("dup_sticky", err_dup_src, FEAT);
        check("clean_d", err_bad_d, 0);

        // Ten D beats with the master ready toggling.
        do_reset();
        sent = 0; recv = 0;
        for (int c = 0; c < 80 && recv < 10; c++) begin
            rand_fields();
            out_d_valid = (sent < 10); out_d_data = sent; out_d_source = 4'(sent);
            in_d_ready = c[0];
            fire_in  = out_d_valid && out_d_ready;
            fire_out = in_d_valid && in_d_ready;
            if (fire_out) begin
                check("stream_order", in_d_data, recv);
                recv++;
            end
            tick();
            if (fire_in) sent++;
        end
        check("stream_total", recv, 10);
        idle(); tick();

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rand_fields();
            in_a_valid = 1'($urandom); in_a_source = 4'($urandom_range(0, 7));
            in_a_address = $urandom();
            out_d_valid = 1'($urandom); out_d_source = 4'($urandom_range(0, 7));
            out_a_ready = ($urandom_range(0, 3) != 0); in_d_ready = ($urandom_range(0, 3) != 0);
            reset = (c == 300);
            tick();
        end
        reset = 0; idle();
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
